// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, branch-operand and multi-cycle FPU interlocks.
// Optional stall statistics counter enabled by defining HAZARD_CTRL_STATS_EN.
module hazard_ctrl #(
  parameter int FPU_LAT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       DecValid,
  input  logic [5:0] DecRs1,
  input  logic [5:0] DecRs2,
  input  logic       DecUsesRs1,
  input  logic       DecUsesRs2,
  input  logic [5:0] DecRd,
  input  logic       DecRegWE,
  input  logic       DecIsLoad,
  input  logic       DecIsFPU,
  input  logic       DecIsBranch,
  output logic       Stall,
  output logic       Bubble,
  output logic       FpuBusy
`ifdef HAZARD_CTRL_STATS_EN
  ,
  output logic [15:0] StallCount
`endif
);

  typedef enum logic {FREE, BUSY} fpu_state_e;

  logic       r_ex_valid, r_ex_we, r_ex_isload;
  logic [5:0] r_ex_rd;
  logic       r_mem_valid, r_mem_we, r_mem_isload;
  logic [5:0] r_mem_rd;

  fpu_state_e r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [5:0] r_fpu_rd, w_fpu_rd_nxt;
  logic       r_fpu_busy;

  logic w_load_use, w_branch, w_fpu_haz, w_stall, w_fpu_issue;
  logic w_ex_rs1, w_ex_rs2, w_br_ex, w_br_mem;

  // Register 0 of either file is hardwired and never creates a dependency.
  function automatic logic slot_match(input logic v, input logic we, input logic [5:0] rd,
                                      input logic [5:0] src, input logic used);
    return v & we & (rd == src) & (src[4:0] != 5'd0) & used;
  endfunction

  assign w_ex_rs1 = slot_match(r_ex_valid, r_ex_we, r_ex_rd, DecRs1, DecUsesRs1);
  assign w_ex_rs2 = slot_match(r_ex_valid, r_ex_we, r_ex_rd, DecRs2, DecUsesRs2);
  assign w_br_ex  = slot_match(r_ex_valid, r_ex_we, r_ex_rd, DecRs1, 1'b1);
  assign w_br_mem = slot_match(r_mem_valid, r_mem_we, r_mem_rd, DecRs1, 1'b1);

  assign w_load_use = r_ex_isload & (w_ex_rs1 | w_ex_rs2);
  assign w_branch   = DecIsBranch & (w_br_ex | (r_mem_isload & w_br_mem));
  assign w_fpu_haz  = (r_state == BUSY) &
                      (DecIsFPU |
                       (DecUsesRs1 & (DecRs1 == r_fpu_rd)) |
                       (DecUsesRs2 & (DecRs2 == r_fpu_rd)) |
                       (DecRegWE & (DecRd == r_fpu_rd)));

  // Gating with reset keeps the outputs quiet while tracking is being discarded.
  assign w_stall     = reset & DecValid & (w_load_use | w_branch | w_fpu_haz);
  assign w_fpu_issue = DecValid & DecIsFPU & ~w_stall;

  assign Stall   = w_stall;
  assign Bubble  = w_stall;
  assign FpuBusy = r_fpu_busy;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ex_valid  <= 1'b0;
      r_mem_valid <= 1'b0;
    end else begin
      r_ex_valid  <= DecValid & ~w_stall;
      r_mem_valid <= r_ex_valid;
    end
  end

  // NOTE: slot payload needs no reset; it is only ever observed qualified by its valid bit.
  always_ff @(posedge clk) begin
    if (DecValid & ~w_stall) begin
      r_ex_rd     <= DecRd;
      r_ex_we     <= DecRegWE;
      r_ex_isload <= DecIsLoad;
    end
    r_mem_rd     <= r_ex_rd;
    r_mem_we     <= r_ex_we;
    r_mem_isload <= r_ex_isload;
  end

  // NOTE: defaults first so no path through the case leaves a variable unassigned (no latch).
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_fpu_rd_nxt = r_fpu_rd;
    case (r_state)
      FREE: begin
        if (w_fpu_issue) begin
          w_state_nxt  = BUSY;
          w_cnt_nxt    = 4'(FPU_LAT - 1);
          w_fpu_rd_nxt = DecRd;
        end
      end
      BUSY: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_state_nxt = FREE;
      end
      default: w_state_nxt = FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= FREE;
      r_cnt      <= 4'd0;
      r_fpu_rd   <= 6'd0;
      r_fpu_busy <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_fpu_rd   <= w_fpu_rd_nxt;
      r_fpu_busy <= (w_cnt_nxt != 4'd0);
    end
  end

`ifdef HAZARD_CTRL_STATS_EN
  logic [15:0] r_stall_count;

  always_ff @(posedge clk) begin
    if (!reset)                                  r_stall_count <= 16'd0;
    else if (w_stall && r_stall_count != 16'hFFFF) r_stall_count <= r_stall_count + 16'd1;
  end

  assign StallCount = r_stall_count;
`else
  // Statistics disabled: no counter is built.
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a history-based reference model predicts each cycle,
// a negedge monitor compares; directed sequences count observed stall cycles.
module tb_hazard_ctrl;
  localparam int LAT = 4;

  typedef struct packed {
    logic       valid;
    logic [5:0] rs1;
    logic       u1;
    logic [5:0] rs2;
    logic       u2;
    logic [5:0] rd;
    logic       we;
    logic       ld;
    logic       fpu;
    logic       br;
  } instr_t;

  typedef struct packed {
    logic        stall;
    logic        busy;
    logic [15:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       DecValid = 1'b0, DecUsesRs1 = 1'b0, DecUsesRs2 = 1'b0;
  logic [5:0] DecRs1 = '0, DecRs2 = '0, DecRd = '0;
  logic       DecRegWE = 1'b0, DecIsLoad = 1'b0, DecIsFPU = 1'b0, DecIsBranch = 1'b0;
  logic       Stall, Bubble, FpuBusy;
`ifdef HAZARD_CTRL_STATS_EN
  logic [15:0] StallCount;
  logic        s_reset = 1'b0, s_valid = 1'b0;
  logic        s_stall, s_bubble, s_busy;
  logic [15:0] s_count;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.FPU_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .DecValid(DecValid),
    .DecRs1(DecRs1), .DecRs2(DecRs2), .DecUsesRs1(DecUsesRs1), .DecUsesRs2(DecUsesRs2),
    .DecRd(DecRd), .DecRegWE(DecRegWE), .DecIsLoad(DecIsLoad), .DecIsFPU(DecIsFPU),
    .DecIsBranch(DecIsBranch), .Stall(Stall), .Bubble(Bubble), .FpuBusy(FpuBusy)
`ifdef HAZARD_CTRL_STATS_EN
    , .StallCount(StallCount)
`endif
  );

`ifdef HAZARD_CTRL_STATS_EN
  // Long-latency instance: a constantly presented FPU op stalls 14 of every 15 cycles.
  hazard_ctrl #(.FPU_LAT(15)) dut_sat (
    .clk(clk), .reset(s_reset), .DecValid(s_valid),
    .DecRs1(6'd0), .DecRs2(6'd0), .DecUsesRs1(1'b0), .DecUsesRs2(1'b0),
    .DecRd(6'd1), .DecRegWE(1'b1), .DecIsLoad(1'b0), .DecIsFPU(1'b1),
    .DecIsBranch(1'b0), .Stall(s_stall), .Bubble(s_bubble), .FpuBusy(s_busy),
    .StallCount(s_count)
  );
`endif

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: history of what entered execute each cycle, plus FPU issue time.
  instr_t     hist[$];
  exp_t       sb_q[$];
  int         n = 0;
  int         fpu_t = -100;
  logic [5:0] fpu_rd = '0;
  int         m_cnt = 0;
  logic       dut_stall_seen, dut_busy_seen;
  logic [15:0] dut_cnt_seen;
  int         busy_cycles = 0;
  localparam instr_t INV = '0;

  function automatic logic m_match(input instr_t e, input logic [5:0] src, input logic used);
    return e.valid && e.we && (e.rd == src) && (src[4:0] != 5'd0) && used;
  endfunction

  function automatic logic m_busy();
    return (n - fpu_t) >= 1 && (n - fpu_t) <= LAT - 1;
  endfunction

  function automatic logic m_stall(input instr_t d, input logic rst_v);
    instr_t ex, mem;
    logic lu, br, fh;
    ex  = hist[hist.size() - 1];
    mem = hist[hist.size() - 2];
    lu  = ex.ld && (m_match(ex, d.rs1, d.u1) || m_match(ex, d.rs2, d.u2));
    br  = d.br && (m_match(ex, d.rs1, 1'b1) || (mem.ld && m_match(mem, d.rs1, 1'b1)));
    fh  = m_busy() && (d.fpu || (d.u1 && d.rs1 == fpu_rd) || (d.u2 && d.rs2 == fpu_rd) ||
                       (d.we && d.rd == fpu_rd));
    return rst_v && d.valid && (lu || br || fh);
  endfunction

  function automatic instr_t mk(input logic v, input logic [5:0] rs1, input logic u1,
                                input logic [5:0] rs2, input logic u2, input logic [5:0] rd,
                                input logic we, input logic ld, input logic fpu, input logic br);
    instr_t d;
    d = '{v, rs1, u1, rs2, u2, rd, we, ld, fpu, br};
    return d;
  endfunction

  function automatic instr_t rnd();
    instr_t d;
    d.valid = ($urandom_range(0, 7) != 0);
    d.rs1   = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 3))};
    d.rs2   = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 3))};
    d.rd    = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 3))};
    d.u1    = 1'($urandom_range(0, 1));
    d.u2    = 1'($urandom_range(0, 1));
    d.fpu   = ($urandom_range(0, 5) == 0);
    d.ld    = !d.fpu && ($urandom_range(0, 3) == 0);
    d.br    = !d.fpu && !d.ld && ($urandom_range(0, 4) == 0);
    if (d.br) d.u1 = 1'b1;
    d.we    = d.ld || d.fpu || (!d.br && $urandom_range(0, 3) != 0);
    return d;
  endfunction

  // One clock: drive, predict, sample, then advance the model past the edge.
  task automatic cyc(input instr_t d, input logic rst_v);
    exp_t e;
    reset       = rst_v;
    DecValid    = d.valid;  DecRs1 = d.rs1; DecRs2 = d.rs2;
    DecUsesRs1  = d.u1;     DecUsesRs2 = d.u2; DecRd = d.rd;
    DecRegWE    = d.we;     DecIsLoad = d.ld; DecIsFPU = d.fpu; DecIsBranch = d.br;
    e.stall = m_stall(d, rst_v);
    e.busy  = m_busy();
    e.cnt   = 16'(m_cnt);
    sb_q.push_back(e);
    @(negedge clk);
    dut_stall_seen = Stall;
    dut_busy_seen  = FpuBusy;
`ifdef HAZARD_CTRL_STATS_EN
    dut_cnt_seen   = StallCount;
`else
    dut_cnt_seen   = 16'd0;
`endif
    if (FpuBusy) busy_cycles++;
    @(posedge clk);
    if (!rst_v) begin
      hist.delete();
      hist.push_back(INV);
      hist.push_back(INV);
      fpu_t  = -100;
      fpu_rd = '0;
      m_cnt  = 0;
    end else begin
      if (d.valid && d.fpu && !e.stall) begin
        fpu_t  = n;
        fpu_rd = d.rd;
      end
      hist.push_back((d.valid && !e.stall) ? d : INV);
      if (hist.size() > 4) void'(hist.pop_front());
      if (e.stall && m_cnt < 65535) m_cnt++;
    end
    n++;
    #1;
  endtask

  // Present an instruction until the DUT lets it through; report stall cycles seen.
  task automatic issue(input instr_t d, output int ns);
    ns = 0;
    for (int k = 0; k <= 20; k++) begin
      cyc(d, 1'b1);
      if (!dut_stall_seen) break;
      ns++;
    end
    if (ns > 20) check("stall_bound", 32'(ns), 32'd20);
  endtask

  task automatic flush(input int k);
    int ns;
    for (int i = 0; i < k; i++) issue(INV, ns);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check("sb_stall",  32'(Stall),   32'(e.stall));
      check("sb_bubble", 32'(Bubble),  32'(e.stall));
      check("sb_busy",   32'(FpuBusy), 32'(e.busy));
`ifdef HAZARD_CTRL_STATS_EN
      check("sb_count",  32'(StallCount), 32'(e.cnt));
`endif
    end
  end

  initial begin
    int ns;
    instr_t fpu_f3, rd_f3;
    hist.push_back(INV);
    hist.push_back(INV);
    repeat (2) @(posedge clk);
    #1;
    cyc(INV, 1'b1);
    check("reset_stall", 32'(dut_stall_seen), 32'd0);
    check("reset_busy",  32'(dut_busy_seen),  32'd0);

    // Load r5 then ADD reading r5.
    issue(mk(1, 6'd0, 0, 6'd0, 0, 6'd5, 1, 1, 0, 0), ns);
    issue(mk(1, 6'd5, 1, 6'd2, 1, 6'd6, 1, 0, 0, 0), ns);
    check("load_use", 32'(ns), 32'd1);
    flush(2);

    // ALU then branch, load then branch.
    issue(mk(1, 6'd1, 1, 6'd2, 1, 6'd7, 1, 0, 0, 0), ns);
    issue(mk(1, 6'd7, 1, 6'd0, 0, 6'd0, 0, 0, 0, 1), ns);
    check("alu_branch", 32'(ns), 32'd1);
    flush(2);
    issue(mk(1, 6'd1, 1, 6'd0, 0, 6'd7, 1, 1, 0, 0), ns);
    issue(mk(1, 6'd7, 1, 6'd0, 0, 6'd0, 0, 0, 0, 1), ns);
    check("load_branch", 32'(ns), 32'd2);
    flush(2);

    // FPU writing f3, then a reader of f3.
    fpu_f3 = mk(1, 6'd1, 1, 6'd2, 1, 6'b100011, 1, 0, 1, 0);
    rd_f3  = mk(1, 6'b100011, 1, 6'd0, 0, 6'd9, 1, 0, 0, 0);
    busy_cycles = 0;
    issue(fpu_f3, ns);
    issue(rd_f3, ns);
    check("fpu_raw", 32'(ns), 32'(LAT - 1));
    check("fpu_busy_len", 32'(busy_cycles), 32'(LAT - 1));
    flush(4);

    // r0 never matches; back-to-back FPU ops serialize.
    issue(mk(1, 6'd1, 1, 6'd0, 0, 6'd0, 1, 1, 0, 0), ns);
    issue(mk(1, 6'd0, 1, 6'd0, 1, 6'd4, 1, 0, 0, 0), ns);
    check("r0_no_stall", 32'(ns), 32'd0);
    flush(2);
    issue(mk(1, 6'd1, 1, 6'd2, 1, 6'b100001, 1, 0, 1, 0), ns);
    issue(mk(1, 6'd1, 1, 6'd2, 1, 6'b100010, 1, 0, 1, 0), ns);
    check("fpu_struct", 32'(ns), 32'(LAT - 1));
    flush(4);

    // Reset during the 2nd stall cycle abandons the countdown.
    issue(fpu_f3, ns);
    cyc(rd_f3, 1'b1);
    cyc(rd_f3, 1'b0);
    check("rst_during_stall", 32'(dut_stall_seen), 32'd0);
    cyc(rd_f3, 1'b1);
    check("rst_after_stall", 32'(dut_stall_seen), 32'd0);
    check("rst_after_busy",  32'(dut_busy_seen),  32'd0);
    check("rst_after_count", 32'(dut_cnt_seen),   32'd0);
    flush(4);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) cyc(rnd(), 1'b0);
      else issue(rnd(), ns);
    end
    flush(4);

`ifdef HAZARD_CTRL_STATS_EN
    s_reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    s_reset = 1'b1;
    s_valid = 1'b1;
    repeat (75100) @(posedge clk);
    #1;
    check("count_saturate", 32'(s_count), 32'hFFFF);
    check("sat_stall_live", 32'(s_busy), 32'(s_busy | s_stall));
`endif

    @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
